// File: rtl/spi_master_nch_if.sv
// Pin and control bundle of spi_master_nch: start/done toward the control FSM,
// SCK/MOSI/MISO/SS toward the SPI bus, plus the FSM state for observation.
interface spi_master_nch_if #(
    parameter int DATA_W = 48,
    parameter int NSS    = 2,
    parameter int DIV_W  = 8
);
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int SEL_W = (NSS > 1) ? $clog2(NSS) : 1;

    logic              spi_start_i;
    logic [1:0]        spi_mode_i;
    logic              spi_fbo_i;
    logic [DIV_W-1:0]  clock_divider_i;
    logic [LEN_W-1:0]  spi_len_i;
    logic [SEL_W-1:0]  spi_ss_sel_i;
    logic              spi_hold_ss_i;
    logic [DATA_W-1:0] transmission_data_i;
    logic [DATA_W-1:0] received_data_o;
    logic              done;
    logic              spi_busy_o;
    logic              SCK;
    logic              MOSI;
    logic              MISO;
    logic [NSS-1:0]    SS;
    logic [2:0]        dbg_state;

    modport master (
        input  spi_start_i, spi_mode_i, spi_fbo_i, clock_divider_i, spi_len_i,
               spi_ss_sel_i, spi_hold_ss_i, transmission_data_i, MISO,
        output received_data_o, done, spi_busy_o, SCK, MOSI, SS, dbg_state
    );

    modport slave (
        output spi_start_i, spi_mode_i, spi_fbo_i, clock_divider_i, spi_len_i,
               spi_ss_sel_i, spi_hold_ss_i, transmission_data_i, MISO,
        input  received_data_o, done, spi_busy_o, SCK, MOSI, SS, dbg_state
    );
endinterface

// File: rtl/spi_master_nch.sv
// SPI master: runtime frame length up to DATA_W, all four modes, MSB/LSB first,
// multiple active-low slave selects with optional hold between frames.
module spi_master_nch #(
    parameter int DATA_W = 48,
    parameter int NSS    = 2,
    parameter int DIV_W  = 8
) (
    input logic               spi_clk_i,
    input logic               spi_rst_i,
    spi_master_nch_if.master  bus
);
    localparam int LEN_W  = $clog2(DATA_W + 1);
    localparam int SEL_W  = (NSS > 1) ? $clog2(NSS) : 1;
    localparam int EDGE_W = LEN_W + 1;

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, cnt_q;
    logic [LEN_W-1:0]  len_q, tx_n_q, rx_n_q, len_in;
    logic [EDGE_W-1:0] edge_q, len2;
    logic              cpha_q, fbo_q, hold_q;
    logic [DATA_W-1:0] tx_q, rx_q, rx_out_q;
    logic              sck_q, mosi_q;
    logic [NSS-1:0]    ss_q, ss_dec;
    logic              hp_end, toggle, lead_edge, last_edge, sample, drive;

    // Handshake: spi_start_i is taken only in IDLE (held or pulsed, one frame
    // per acceptance); done pulses for exactly one cycle as spi_busy_o drops.
    function automatic logic [LEN_W-1:0] bit_pos(input logic [LEN_W-1:0] len,
                                                 input logic fbo,
                                                 input logic [LEN_W-1:0] n);
        return fbo ? n : (len - LEN_W'(1) - n);
    endfunction

    always_comb begin
        len_in = bus.spi_len_i;
        if (bus.spi_len_i == '0 || bus.spi_len_i > LEN_W'(DATA_W))
            len_in = LEN_W'(DATA_W);
        ss_dec = '1;
        for (int i = 0; i < NSS; i++)
            ss_dec[i] = (bus.spi_ss_sel_i != SEL_W'(i));
    end

    // Edge k (1-based) is leading when odd; edge_q holds edges already made.
    assign len2      = {len_q, 1'b0};
    assign hp_end    = (cnt_q == '0);
    assign toggle    = hp_end && (state_q == LEAD || (state_q == XFER && edge_q != len2));
    assign lead_edge = ~edge_q[0];
    assign last_edge = ((edge_q + EDGE_W'(1)) == len2);
    assign sample    = toggle && (cpha_q ? ~lead_edge : lead_edge);
    assign drive     = toggle && (cpha_q ? lead_edge : (~lead_edge && ~last_edge));

    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.spi_start_i) state_d = LEAD;
            LEAD:    if (hp_end) state_d = XFER;
            XFER:    if (hp_end && edge_q == len2) state_d = TRAIL;
            TRAIL:   if (hp_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            div_q <= '0; cnt_q <= '0; len_q <= '0; tx_n_q <= '0; rx_n_q <= '0;
            edge_q <= '0; cpha_q <= 1'b0; fbo_q <= 1'b0; hold_q <= 1'b0;
            tx_q <= '0; rx_q <= '0; rx_out_q <= '0;
            sck_q <= 1'b0; mosi_q <= 1'b1; ss_q <= '1;
        end else if (state_q == IDLE) begin
            sck_q  <= bus.spi_mode_i[1];
            mosi_q <= 1'b1;
            if (bus.spi_start_i) begin
                div_q  <= bus.clock_divider_i;
                cnt_q  <= bus.clock_divider_i;
                len_q  <= len_in;
                cpha_q <= bus.spi_mode_i[0];
                fbo_q  <= bus.spi_fbo_i;
                hold_q <= bus.spi_hold_ss_i;
                tx_q   <= bus.transmission_data_i;
                rx_q   <= '0;
                edge_q <= '0;
                rx_n_q <= '0;
                ss_q   <= ss_dec;
                // CPHA=0 presents the first bit for the whole LEAD half-period.
                if (!bus.spi_mode_i[0]) begin
                    mosi_q <= bus.transmission_data_i[bit_pos(len_in, bus.spi_fbo_i, '0)];
                    tx_n_q <= LEN_W'(1);
                end else begin
                    tx_n_q <= '0;
                end
            end
        end else begin
            cnt_q <= hp_end ? div_q : (cnt_q - DIV_W'(1));
            if (toggle) begin
                sck_q  <= ~sck_q;
                edge_q <= edge_q + EDGE_W'(1);
            end
            if (sample) begin
                rx_q[bit_pos(len_q, fbo_q, rx_n_q)] <= bus.MISO;
                rx_n_q <= rx_n_q + LEN_W'(1);
            end
            if (drive) begin
                mosi_q <= tx_q[bit_pos(len_q, fbo_q, tx_n_q)];
                tx_n_q <= tx_n_q + LEN_W'(1);
            end
            if (state_q == TRAIL && hp_end) begin
                rx_out_q <= rx_q;
                mosi_q   <= 1'b1;
                if (!hold_q) ss_q <= '1;
            end
        end
    end

    assign bus.received_data_o = rx_out_q;
    assign bus.done            = (state_q == DONE);
    assign bus.spi_busy_o      = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL);
    assign bus.SCK             = sck_q;
    assign bus.MOSI            = mosi_q;
    assign bus.SS              = ss_q;
    assign bus.dbg_state       = state_q;
endmodule
